// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, flag register layout and FSM states.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_PASSA = 4'b0000,
      OP_PASSB = 4'b0001,
      OP_NOTA  = 4'b0010,
      OP_NOTB  = 4'b0011,
      OP_ADD   = 4'b0100,
      OP_ADC   = 4'b0101,
      OP_OR    = 4'b0110,
      OP_AND   = 4'b0111,
      OP_ZERO  = 4'b1000,
      OP_ONE   = 4'b1001,
      OP_ONES  = 4'b1010,
      OP_CLRC  = 4'b1011,
      OP_SETC  = 4'b1100,
      OP_SUB   = 4'b1101,
      OP_SHL   = 4'b1110,
      OP_SHR   = 4'b1111
   } alu_op_e;

   typedef struct packed {
      logic c;
      logic z;
      logic n;
      logic v;
   } alu_flags_t;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } alu_state_e;

endpackage

// File: rtl/alu_shifter.sv
// Iterative logical shifter: one bit per clock; result/carry present the value of the current step.
module alu_shifter
   import alu_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int SHAMT_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               dir,
   input  logic [WIDTH-1:0]   a,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               done,
   output logic [WIDTH-1:0]   result,
   output logic               carry
);

   logic [WIDTH-1:0]   work_q, work_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic               dir_q, dir_d;
   logic [WIDTH-1:0]   shifted_s;
   logic               out_bit_s;

   // One-bit step of the working value; dir=1 shifts right.
   always_comb begin
      shifted_s = work_q;
      out_bit_s = 1'b0;
      if (dir_q) begin
         shifted_s = {1'b0, work_q[WIDTH-1:1]};
         out_bit_s = work_q[0];
      end else begin
         shifted_s = {work_q[WIDTH-2:0], 1'b0};
         out_bit_s = work_q[WIDTH-1];
      end
   end

   // Next-state for the work/count registers.
   always_comb begin
      work_d = work_q;
      cnt_d  = cnt_q;
      dir_d  = dir_q;
      if (load) begin
         work_d = a;
         cnt_d  = shamt;
         dir_d  = dir;
      end else if (cnt_q != {SHAMT_W{1'b0}}) begin
         work_d = shifted_s;
         cnt_d  = cnt_q - {{(SHAMT_W-1){1'b0}}, 1'b1};
      end else begin
         work_d = work_q;
      end
   end

   // Shift engine state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work_q <= {WIDTH{1'b0}};
         cnt_q  <= {SHAMT_W{1'b0}};
         dir_q  <= 1'b0;
      end else begin
         work_q <= work_d;
         cnt_q  <= cnt_d;
         dir_q  <= dir_d;
      end
   end

   // done marks the edge that performs the final shift.
   assign done   = (cnt_q == {{(SHAMT_W-1){1'b0}}, 1'b1});
   assign result = shifted_s;
   assign carry  = out_bit_s;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with persistent C/Z/N/V flags, valid/ready input and iterative shifts.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       aluc,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic [WIDTH-1:0] z,
   output logic             cy_out,
   output logic             zero,
   output logic             neg,
   output logic             ovf,
   output logic             busy
);

   localparam int SHAMT_W = $clog2(WIDTH);

   alu_state_e         state_q, state_d;
   logic [WIDTH-1:0]   z_q, z_d;
   alu_flags_t         flags_q, flags_d;
   logic               out_valid_q, out_valid_d;

   logic [SHAMT_W-1:0] shamt_s;
   logic [WIDTH-1:0]   b_op_s;
   logic               cin_s;
   logic [WIDTH:0]     sum_s;
   logic               sum_ovf_s;
   logic [WIDTH-1:0]   res_s;
   logic               wr_z_s, c_new_s, v_new_s, go_shift_s;
   logic               sh_load_s, sh_done_s, sh_carry_s;
   logic [WIDTH-1:0]   sh_result_s;

   assign shamt_s = b[SHAMT_W-1:0];

   // Shared adder: SUB is a + ~b + 1, ADC pulls in the registered carry.
   always_comb begin
      b_op_s = b;
      cin_s  = 1'b0;
      case (alu_op_e'(aluc))
         OP_SUB:  begin b_op_s = ~b; cin_s = 1'b1;      end
         OP_ADC:  begin b_op_s = b;  cin_s = flags_q.c; end
         default: begin b_op_s = b;  cin_s = 1'b0;      end
      endcase
      sum_s     = {1'b0, a} + {1'b0, b_op_s} + {{WIDTH{1'b0}}, cin_s};
      sum_ovf_s = (a[WIDTH-1] == b_op_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
   end

   // Single-cycle opcode decode.
   always_comb begin
      res_s      = z_q;
      wr_z_s     = 1'b1;
      c_new_s    = flags_q.c;
      v_new_s    = 1'b0;
      go_shift_s = 1'b0;
      case (alu_op_e'(aluc))
         OP_PASSA: res_s = a;
         OP_PASSB: res_s = b;
         OP_NOTA:  res_s = ~a;
         OP_NOTB:  res_s = ~b;
         OP_ADD, OP_ADC, OP_SUB: begin
            res_s   = sum_s[WIDTH-1:0];
            c_new_s = sum_s[WIDTH];
            v_new_s = sum_ovf_s;
         end
         OP_OR:    res_s = a | b;
         OP_AND:   res_s = a & b;
         OP_ZERO:  res_s = {WIDTH{1'b0}};
         OP_ONE:   res_s = {{(WIDTH-1){1'b0}}, 1'b1};
         OP_ONES:  res_s = {WIDTH{1'b1}};
         OP_CLRC:  begin wr_z_s = 1'b0; c_new_s = 1'b0; end
         OP_SETC:  begin wr_z_s = 1'b0; c_new_s = 1'b1; end
         OP_SHL, OP_SHR: begin
            if (shamt_s == {SHAMT_W{1'b0}}) begin
               res_s = a;
            end else begin
               wr_z_s     = 1'b0;
               go_shift_s = 1'b1;
            end
         end
         default:  wr_z_s = 1'b0;
      endcase
   end

   // Handshake FSM and result/flag next-state.
   always_comb begin
      state_d     = state_q;
      z_d         = z_q;
      flags_d     = flags_q;
      out_valid_d = 1'b0;
      sh_load_s   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (go_shift_s) begin
                  sh_load_s = 1'b1;
                  state_d   = S_SHIFT;
               end else begin
                  out_valid_d = 1'b1;
                  flags_d.c   = c_new_s;
                  if (wr_z_s) begin
                     z_d       = res_s;
                     flags_d.z = (res_s == {WIDTH{1'b0}});
                     flags_d.n = res_s[WIDTH-1];
                     flags_d.v = v_new_s;
                  end else begin
                     z_d = z_q;
                  end
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SHIFT: begin
            if (sh_done_s) begin
               z_d         = sh_result_s;
               flags_d.c   = sh_carry_s;
               flags_d.z   = (sh_result_s == {WIDTH{1'b0}});
               flags_d.n   = sh_result_s[WIDTH-1];
               flags_d.v   = 1'b0;
               out_valid_d = 1'b1;
               state_d     = S_IDLE;
            end else begin
               state_d = S_SHIFT;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, result and flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         z_q         <= {WIDTH{1'b0}};
         flags_q     <= '{c: 1'b0, z: 1'b0, n: 1'b0, v: 1'b0};
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         z_q         <= z_d;
         flags_q     <= flags_d;
         out_valid_q <= out_valid_d;
      end
   end

   alu_shifter #(
      .WIDTH   (WIDTH),
      .SHAMT_W (SHAMT_W)
   ) u_shifter (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (sh_load_s),
      .dir    (aluc == OP_SHR),
      .a      (a),
      .shamt  (shamt_s),
      .done   (sh_done_s),
      .result (sh_result_s),
      .carry  (sh_carry_s)
   );

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q == S_SHIFT);
   assign out_valid = out_valid_q;
   assign z         = z_q;
   assign cy_out    = flags_q.c;
   assign zero      = flags_q.z;
   assign neg       = flags_q.n;
   assign ovf       = flags_q.v;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed vectors queue expected results, a monitor checks each out_valid.
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  aluc;
   logic [15:0] a, b;
   logic        out_valid;
   logic [15:0] z;
   logic        cy_out, zero, neg, ovf, busy;

   typedef struct {
      logic [15:0] z;
      logic [3:0]  f;
      int          cyc;
      string       name;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;

   alu_seq #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .aluc(aluc), .a(a), .b(b), .out_valid(out_valid), .z(z),
      .cy_out(cy_out), .zero(zero), .neg(neg), .ovf(ovf), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every out_valid pops one expectation, compares result, flags and arrival cycle.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         exp_t e;
         n_vec++;
         if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_out_valid: got out_valid=1 z=%h at cycle %0d, required no result", z, cyc);
         end else begin
            e = q.pop_front();
            if (z !== e.z || {cy_out, zero, neg, ovf} !== e.f || cyc != e.cyc) begin
               n_err++;
               $display("FAIL %s: got z=%h CZNV=%b cycle=%0d, required z=%h CZNV=%b cycle=%0d",
                        e.name, z, {cy_out, zero, neg, ovf}, cyc, e.z, e.f, e.cyc);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
      n_vec++;
      if (got !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   // Present an op, hold it until accepted, then queue its hand-computed result (flags as CZNV).
   task automatic issue(input logic [3:0] op, input logic [15:0] va, input logic [15:0] vb,
                        input logic [15:0] ez, input logic [3:0] ef, input int lat,
                        input bit push, input string name);
      int waited = 0;
      @(negedge clk);
      aluc = op; a = va; b = vb; in_valid = 1'b1;
      while (!in_ready && waited < 64) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL %s_accept: got in_ready=0 after %0d cycles, required 1", name, waited);
      end
      if (push) q.push_back('{ez, ef, cyc + lat, name});
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic chk_reset(input string name);
      chk(name, {z, cy_out, zero, neg, ovf, out_valid, busy, in_ready},
                {16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
   endtask

   initial begin
      int waited;
      rst_n = 1'b0; in_valid = 1'b0; aluc = 4'h0; a = 16'h0; b = 16'h0;
      repeat (2) @(negedge clk);
      chk_reset("reset_state");
      rst_n = 1'b1;

      //      op     a         b         z         CZNV     lat
      issue(4'h4, 16'hFFFF, 16'h0001, 16'h0000, 4'b1100, 1, 1'b1, "add_wrap");
      issue(4'h4, 16'h7FFF, 16'h0001, 16'h8000, 4'b0011, 1, 1'b1, "add_ovf");
      issue(4'h5, 16'h0000, 16'h0000, 16'h0000, 4'b0100, 1, 1'b1, "adc_b2b");
      issue(4'hC, 16'h1111, 16'h2222, 16'h0000, 4'b1100, 1, 1'b1, "setc");
      issue(4'h5, 16'h0005, 16'h0003, 16'h0009, 4'b0000, 1, 1'b1, "adc_carry_in");
      issue(4'hD, 16'h0003, 16'h0005, 16'hFFFE, 4'b0010, 1, 1'b1, "sub_3_5");
      issue(4'hD, 16'h0005, 16'h0003, 16'h0002, 4'b1000, 1, 1'b1, "sub_5_3");
      issue(4'hD, 16'h8000, 16'h0001, 16'h7FFF, 4'b1001, 1, 1'b1, "sub_ovf");
      issue(4'h6, 16'h0F0F, 16'h00FF, 16'h0FFF, 4'b1000, 1, 1'b1, "or");
      issue(4'h7, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b1000, 1, 1'b1, "and");
      issue(4'h2, 16'h0000, 16'h1234, 16'hFFFF, 4'b1010, 1, 1'b1, "nota");
      issue(4'h0, 16'hA5A5, 16'h0000, 16'hA5A5, 4'b1010, 1, 1'b1, "passa");
      issue(4'h3, 16'h0000, 16'h00FF, 16'hFF00, 4'b1010, 1, 1'b1, "notb");
      issue(4'h1, 16'h1234, 16'h0000, 16'h0000, 4'b1100, 1, 1'b1, "passb_zero");
      issue(4'h9, 16'h0000, 16'h0000, 16'h0001, 4'b1000, 1, 1'b1, "one");
      issue(4'hA, 16'h0000, 16'h0000, 16'hFFFF, 4'b1010, 1, 1'b1, "ones");
      issue(4'hB, 16'h0000, 16'h0000, 16'hFFFF, 4'b0010, 1, 1'b1, "clrc");

      // SHL by 4 with the following SHR held on the inputs while busy.
      issue(4'hE, 16'h8001, 16'h0004, 16'h0010, 4'b0000, 5, 1'b1, "shl_8001_4");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) begin
            aluc = 4'hF; a = 16'h0003; b = 16'h0001; in_valid = 1'b1;
         end
         chk("shift_busy_ready", {30'h0, busy, in_ready}, {30'h0, 1'b1, 1'b0});
      end
      issue(4'hF, 16'h0003, 16'h0001, 16'h0001, 4'b1000, 2, 1'b1, "shr_0003_1");
      issue(4'hE, 16'h1234, 16'h0000, 16'h1234, 4'b1000, 1, 1'b1, "shl_shamt0");
      issue(4'hF, 16'h8000, 16'h000F, 16'h0001, 4'b0000, 16, 1'b1, "shr_8000_15");

      // Abort a long shift with reset.
      issue(4'hE, 16'hFFFF, 16'h000F, 16'h0000, 4'b0000, 16, 1'b0, "shl_abort");
      repeat (2) @(negedge clk);
      chk("abort_busy_before", {31'h0, busy}, 32'h1);
      @(negedge clk);
      rst_n = 1'b0;
      #1 chk_reset("abort_reset_state");
      @(negedge clk);
      chk_reset("abort_reset_held");
      rst_n = 1'b1;

      issue(4'h4, 16'h1234, 16'h1111, 16'h2345, 4'b0000, 1, 1'b1, "add_after_reset");
      issue(4'h5, 16'h8000, 16'h8000, 16'h0000, 4'b1101, 1, 1'b1, "adc_neg_ovf");
      issue(4'h8, 16'h5555, 16'h5555, 16'h0000, 4'b1100, 1, 1'b1, "zero_op");

      waited = 0;
      while (q.size() != 0 && waited < 64) begin
         @(negedge clk);
         waited++;
      end
      repeat (2) @(negedge clk);
      chk("scoreboard_drained", q.size(), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor of the EV22 16-bit combinational ALU. It sits between the register file and the result bus. It adds a persistent flag register (C, Z, N, V) so that ADC genuinely consumes the stored carry. It adds a valid/ready input handshake, and provides multi-cycle iterative shifts that shift one bit per clock.

## Interface
- WIDTH, 16, datapath width in bits; must be ≥ 4.
- SHAMT_W, derived localparam = $clog2(WIDTH); not overridable.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation.
- aluc  in  4  opcode.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; b[SHAMT_W-1:0] is the shift amount for shifts.
- out_valid  out  1  one-cycle pulse: z/flags updated by the completed op.
- z  out  WIDTH  registered result.
- cy_out  out  1  carry flag C.
- zero  out  1  Z flag.
- neg  out  1  N flag.
- ovf  out  1  V flag.
- busy  out  1  high while in SHIFT state.

## Operation
- An operation is accepted when in_valid && in_ready. Inputs are sampled only on the accept edge.
- Opcodes:
  - 0000 z=a; 0001 z=b; 0010 z=~a; 0011 z=~b.
  - 0100 ADD {C,z}=a+b; 0101 ADC {C,z}=a+b+C.
  - 0110 OR; 0111 AND.
  - 1000 z=0; 1001 z=1; 1010 z=all-ones.
  - 1011 CLRC (C=0); 1100 SETC (C=1).
  - 1101 SUB z=a+~b+1, C=carry-out (1 means no borrow).
  - 1110 SHL logical by shamt; 1111 SHR logical by shamt.
- Flag rules:
  - Every op that writes z also writes Z=(z==0) and N=z[WIDTH-1].
  - V for ADD/ADC: a and b have the same sign and the result sign differs. V for SUB: a and b have different signs and the result sign differs from a.
  - V is cleared by all other z-writing ops.
  - C is written only by ADD, ADC, SUB, CLRC, SETC, and shifts with shamt≠0. For shifts, C is the last bit shifted out.
- CLRC/SETC leave z, Z, N, V unchanged but still pulse out_valid.
- All arithmetic is modulo 2^WIDTH. The carry is bit WIDTH of the (WIDTH+1)-bit sum.
- State machine:
  - IDLE: in_ready=1.
    - On accept of a non-shift op, or a shift with shamt=0, z/flags are written and out_valid is set at the accept edge; state stays IDLE.
    - A shift with shamt=0 gives z=a and leaves C unchanged.
    - On accept of a shift with shamt≠0, load work=a, cnt=shamt, and go to SHIFT.
  - SHIFT: in_ready=0, busy=1.
    - Each edge shifts work by one bit, captures the shifted-out bit, and decrements cnt.
    - On the edge where cnt==1: write z, flags and out_valid, then return to IDLE.
- in_valid while in_ready=0 is ignored; the requester must hold it.

## Timing
- Reset values: z=0, C=Z=N=V=0, out_valid=0, busy=0. in_ready=1 (state IDLE).
- Non-shift op or shamt=0, accepted in cycle T: out_valid high in T+1 only.
- Shift with shamt=k≥1, accepted in T:
  - busy and in_ready=0 during T+1..T+k.
  - out_valid high in T+k+1.
- in_ready is high again in the cycle out_valid is high, so back-to-back operations are legal.
- Single-cycle ops may be accepted every cycle; out_valid stays high continuously in that case.
- ADC issued back-to-back after ADD uses the C written by the ADD (the registered value at its accept edge).
- Asserting rst_n low mid-shift aborts the shift immediately. No out_valid is produced, and all outputs take their reset values asynchronously.
- z and the flags hold their values between operations.

## Structure
- Shared package alu_pkg:
  - opcode constants (OP_PASSA … OP_SHR) as a 4-bit enum;
  - a flags struct {c, z, n, v};
  - the state enum {S_IDLE, S_SHIFT}.
- Sub-module alu_shifter: the iterative shift engine.
  - Inputs: load, dir, a, shamt.
  - Outputs: done, result, carry.
  - Owns the work and cnt registers.
- Top-level alu_seq contains the single-cycle datapath, the flag register and the handshake.

## Test plan
- Reset, then ADD a=16'hFFFF b=16'h0001 → in T+1: z=0000, C=1, Z=1, N=0, V=0, out_valid=1.
- ADD 16'h7FFF+16'h0001, then ADC 16'h0000+16'h0000 back-to-back → first result z=8000, V=1, N=1, C=0; second result z=0000, Z=1.
- SETC then ADC a=5 b=3 → z=0009; C=0 after the ADC; z is unchanged by the SETC.
- SUB 3−5 → z=FFFE, C=0, N=1. SUB 5−3 → z=0002, C=1.
- SHL a=16'h8001 shamt=4:
  - busy for 4 cycles, in_ready=0, in_valid held;
  - out_valid at T+5 with z=0010, C=0;
  - SHR a=16'h0003 shamt=1 → z=0001, C=1.
- Start SHL shamt=15, drop rst_n at T+3 → no out_valid; all outputs are 0 and in_ready=1 immediately. A new ADD accepted after reset completes normally.
